// File: rtl/wbarb_rr2_if.sv
// wbarb_rr2_if -- bus bundle for the two-master Wishbone round-robin arbiter.
//
// Carries both master ports (a = instruction, b = data) and the shared slave port.
// Names keep the arbiter's point of view: i_* are driven into the arbiter,
// o_* are driven by it.
//
// Modports:
//   master : the arbiter itself (drives o_*, samples i_*); it masters the slave bus.
//   slave  : the environment (masters a/b and the slave device) around the arbiter.
//
// Parameters: AW address width, DW data width; SW = DW/8 byte selects.
interface wbarb_rr2_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    localparam int unsigned SW = DW / 8;

    // Master a
    logic          i_a_cyc;
    logic          i_a_stb;
    logic          i_a_we;
    logic [AW-1:0] i_a_addr;
    logic [DW-1:0] i_a_data;
    logic [SW-1:0] i_a_sel;
    logic          o_a_ack;
    logic          o_a_err;
    logic [DW-1:0] o_a_data;

    // Master b
    logic          i_b_cyc;
    logic          i_b_stb;
    logic          i_b_we;
    logic [AW-1:0] i_b_addr;
    logic [DW-1:0] i_b_data;
    logic [SW-1:0] i_b_sel;
    logic          o_b_ack;
    logic          o_b_err;
    logic [DW-1:0] o_b_data;

    // Slave
    logic          o_cyc;
    logic          o_stb;
    logic          o_we;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_data;
    logic [SW-1:0] o_sel;
    logic          i_ack;
    logic          i_err;
    logic [DW-1:0] i_data;
    logic [1:0]    o_grant;

    modport master (
        input  i_a_cyc, i_a_stb, i_a_we, i_a_addr, i_a_data, i_a_sel,
        output o_a_ack, o_a_err, o_a_data,
        input  i_b_cyc, i_b_stb, i_b_we, i_b_addr, i_b_data, i_b_sel,
        output o_b_ack, o_b_err, o_b_data,
        output o_cyc, o_stb, o_we, o_addr, o_data, o_sel, o_grant,
        input  i_ack, i_err, i_data
    );

    modport slave (
        output i_a_cyc, i_a_stb, i_a_we, i_a_addr, i_a_data, i_a_sel,
        input  o_a_ack, o_a_err, o_a_data,
        output i_b_cyc, i_b_stb, i_b_we, i_b_addr, i_b_data, i_b_sel,
        input  o_b_ack, o_b_err, o_b_data,
        input  o_cyc, o_stb, o_we, o_addr, o_data, o_sel, o_grant,
        output i_ack, i_err, i_data
    );
endinterface

// File: rtl/wbarb_rr2.sv
// wbarb_rr2 -- two-master classic Wishbone arbiter with round-robin tie break.
//
// Ports:
//   i_clk   : clock.
//   i_reset : synchronous, active-high reset.
//   bus     : wbarb_rr2_if.master -- master a/b ports, slave port and o_grant.
//
// The grant is registered (IDLE/GNT_A/GNT_B, o_grant = 00/01/10). Once granted, a
// master keeps the bus until it drops cyc; the slave-side strobe and attributes
// are muxed combinationally from the owner. A tie in IDLE goes to the master that
// was not granted last.
//
// Optional feature, enabled by defining WBARB_TIMEOUT_EN: a per-strobe wait counter
// that answers a silent slave with a one-cycle error after TIMEOUT cycles and then
// keeps the strobe low until the owner releases the bus.
module wbarb_rr2 #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input logic          i_clk,
    input logic          i_reset,
    wbarb_rr2_if.master  bus
);
    localparam int unsigned SW = DW / 8;

    // Encoding doubles as the one-hot o_grant value.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StGntA = 2'b01,
        StGntB = 2'b10
    } state_e;

    state_e state_q, state_d;
    logic   ptr_b_q, ptr_b_d;  // 1: b was granted last, so a wins the next tie

    logic          own_a, own_b;
    logic          own_cyc, own_stb;
    logic          tmo_hit;    // timeout error fires this cycle
    logic          tmo_block;  // timeout already reported; hold strobe low
    logic          err_any;
    logic [AW-1:0] addr_mux;
    logic [DW-1:0] data_mux;
    logic [SW-1:0] sel_mux;

    assign own_a = (state_q == StGntA);
    assign own_b = (state_q == StGntB);

    // Next-state and round-robin pointer.
    always_comb begin
        state_d = state_q;
        ptr_b_d = ptr_b_q;
        unique case (state_q)
            StIdle: begin
                if (bus.i_a_cyc && bus.i_b_cyc) begin
                    state_d = ptr_b_q ? StGntA : StGntB;
                end else if (bus.i_a_cyc) begin
                    state_d = StGntA;
                end else if (bus.i_b_cyc) begin
                    state_d = StGntB;
                end
            end
            StGntA: begin
                if (!bus.i_a_cyc) begin
                    state_d = bus.i_b_cyc ? StGntB : StIdle;
                end
            end
            StGntB: begin
                if (!bus.i_b_cyc) begin
                    state_d = bus.i_a_cyc ? StGntA : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (state_d != state_q) begin
            if (state_d == StGntA) begin
                ptr_b_d = 1'b0;
            end else if (state_d == StGntB) begin
                ptr_b_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= StIdle;
            ptr_b_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_b_q <= ptr_b_d;
        end
    end

`ifdef WBARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tmo_done_q, tmo_done_d;
    logic            stb_req;

    // Strobe the owner is asking for, before the timeout forces it low.
    assign stb_req   = own_cyc & own_stb & ~tmo_done_q;
    assign tmo_hit   = stb_req & (cnt_q == CntW'(TIMEOUT));
    assign tmo_block = tmo_done_q;

    always_comb begin
        cnt_d      = cnt_q + CntW'(1);
        tmo_done_d = tmo_done_q;
        if ((state_d != state_q) || !stb_req || bus.i_ack || bus.i_err || tmo_hit) begin
            cnt_d = '0;
        end
        if (state_d != state_q) begin
            tmo_done_d = 1'b0;
        end else if (tmo_hit) begin
            tmo_done_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q      <= '0;
            tmo_done_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            tmo_done_q <= tmo_done_d;
        end
    end
`else
    logic unused_timeout;

    assign tmo_hit        = 1'b0;
    assign tmo_block      = 1'b0;
    assign unused_timeout = |TIMEOUT;
`endif

    // Owner mux and response steering.
    always_comb begin
        own_cyc  = 1'b0;
        own_stb  = 1'b0;
        addr_mux = bus.i_a_addr;
        data_mux = bus.i_a_data;
        sel_mux  = bus.i_a_sel;
        if (own_a) begin
            own_cyc = bus.i_a_cyc;
            own_stb = bus.i_a_stb;
        end else if (own_b) begin
            own_cyc  = bus.i_b_cyc;
            own_stb  = bus.i_b_stb;
            addr_mux = bus.i_b_addr;
            data_mux = bus.i_b_data;
            sel_mux  = bus.i_b_sel;
        end
    end

    assign err_any = bus.i_err | tmo_hit;

    assign bus.o_grant = state_q;
    assign bus.o_cyc   = own_cyc;
    assign bus.o_stb   = own_cyc & own_stb & ~tmo_hit & ~tmo_block;
    assign bus.o_we    = (own_a & bus.i_a_we) | (own_b & bus.i_b_we);
    assign bus.o_addr  = addr_mux;
    assign bus.o_data  = data_mux;
    assign bus.o_sel   = sel_mux;

    // Error wins over a simultaneous ack.
    assign bus.o_a_ack = own_a & bus.i_ack & ~err_any;
    assign bus.o_a_err = own_a & err_any;
    assign bus.o_b_ack = own_b & bus.i_ack & ~err_any;
    assign bus.o_b_err = own_b & err_any;

    assign bus.o_a_data = bus.i_data;
    assign bus.o_b_data = bus.i_data;
endmodule

// File: tb/tb_wbarb_rr2.sv
module tb_wbarb_rr2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    wbarb_rr2_if #(.AW(AW), .DW(DW)) bus ();

    wbarb_rr2 #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: current owner (0 none, 1 a, 2 b) and last granted master.
    int own  = 0;
    int last = 2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.i_a_cyc = 0; bus.i_a_stb = 0; bus.i_a_we = 0;
        bus.i_a_addr = '0; bus.i_a_data = '0; bus.i_a_sel = '0;
        bus.i_b_cyc = 0; bus.i_b_stb = 0; bus.i_b_we = 0;
        bus.i_b_addr = '0; bus.i_b_data = '0; bus.i_b_sel = '0;
        bus.i_ack = 0; bus.i_err = 0; bus.i_data = '0;
    endtask

    task automatic new_attr_a();
        bus.i_a_addr = $urandom; bus.i_a_data = $urandom;
        bus.i_a_sel = 4'($urandom_range(0, 15)); bus.i_a_we = 1'($urandom_range(0, 1));
    endtask

    task automatic new_attr_b();
        bus.i_b_addr = $urandom; bus.i_b_data = $urandom;
        bus.i_b_sel = 4'($urandom_range(0, 15)); bus.i_b_we = 1'($urandom_range(0, 1));
    endtask

    // Grant rules applied at a clock edge.
    task automatic model_edge();
        logic mine, other;
        if (rst) begin
            own = 0;
            last = 2;
        end else if (own == 0) begin
            if (bus.i_a_cyc && bus.i_b_cyc) own = (last == 2) ? 1 : 2;
            else if (bus.i_a_cyc) own = 1;
            else if (bus.i_b_cyc) own = 2;
            if (own != 0) last = own;
        end else begin
            mine  = (own == 1) ? bus.i_a_cyc : bus.i_b_cyc;
            other = (own == 1) ? bus.i_b_cyc : bus.i_a_cyc;
            if (!mine) begin
                own = other ? 3 - own : 0;
                if (own != 0) last = own;
            end
        end
    endtask

    // Inputs are already driven; check mid-cycle, then cross the edge.
    task automatic step();
        logic oc, os;
        logic [1:0] g;
        #4;
        oc = (own == 1) ? bus.i_a_cyc : (own == 2) ? bus.i_b_cyc : 1'b0;
        os = (own == 1) ? bus.i_a_stb : (own == 2) ? bus.i_b_stb : 1'b0;
        g  = (own == 1) ? 2'b01 : (own == 2) ? 2'b10 : 2'b00;
        chk("grant", 64'(bus.o_grant), 64'(g));
        chk("cyc", 64'(bus.o_cyc), 64'(oc));
        chk("stb", 64'(bus.o_stb), 64'(oc & os));
        chk("a_ack", 64'(bus.o_a_ack), 64'(own == 1 && bus.i_ack && !bus.i_err));
        chk("a_err", 64'(bus.o_a_err), 64'(own == 1 && bus.i_err));
        chk("b_ack", 64'(bus.o_b_ack), 64'(own == 2 && bus.i_ack && !bus.i_err));
        chk("b_err", 64'(bus.o_b_err), 64'(own == 2 && bus.i_err));
        chk("rdata", {bus.o_a_data, bus.o_b_data}, {bus.i_data, bus.i_data});
        if (own == 1) begin
            chk("we_a", 64'(bus.o_we), 64'(bus.i_a_we));
            chk("attr_a", {bus.o_addr, bus.o_data}, {bus.i_a_addr, bus.i_a_data});
            chk("sel_a", 64'(bus.o_sel), 64'(bus.i_a_sel));
        end else if (own == 2) begin
            chk("we_b", 64'(bus.o_we), 64'(bus.i_b_we));
            chk("attr_b", {bus.o_addr, bus.o_data}, {bus.i_b_addr, bus.i_b_data});
            chk("sel_b", 64'(bus.o_sel), 64'(bus.i_b_sel));
        end else begin
            chk("we_idle", 64'(bus.o_we), 64'd0);
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        own = 0;
        last = 2;
    endtask

    initial begin
        logic a_resp, b_resp, ostb, e_err, e_stb;
        int   a_n, b_n, wait_c;

        idle_inputs();
        do_reset();

        // Reset state.
        step();

        // a alone: grant after one cycle, ack on cycle 3.
        bus.i_a_cyc = 1; bus.i_a_stb = 1; new_attr_a();
        step(); step(); step();
        bus.i_ack = 1; bus.i_data = 32'hCAFE_0001;
        step();
        bus.i_ack = 0; bus.i_a_cyc = 0; bus.i_a_stb = 0;
        step(); step();

        // Simultaneous request after reset: a first, then b without an IDLE gap.
        do_reset();
        bus.i_a_cyc = 1; bus.i_a_stb = 1; new_attr_a();
        bus.i_b_cyc = 1; bus.i_b_stb = 1; new_attr_b();
        step();
        bus.i_ack = 1;
        step();
        bus.i_ack = 0; bus.i_a_cyc = 0; bus.i_a_stb = 0;
        step();
        chk("handover", 64'(bus.o_grant), 64'(2'b10));
        bus.i_ack = 1;
        step();
        bus.i_ack = 0; bus.i_b_cyc = 0; bus.i_b_stb = 0;
        step();

        // b holds the bus 20 cycles while a waits.
        bus.i_b_cyc = 1; bus.i_b_stb = 0; new_attr_b();
        step();
        bus.i_a_cyc = 1; bus.i_a_stb = 1; new_attr_a();
        for (int i = 0; i < 20; i++) begin
            step();
        end
        bus.i_b_cyc = 0;
        step();
        chk("a_after_b", 64'(bus.o_grant), 64'(2'b01));

        // ack and err together: err wins.
        bus.i_ack = 1; bus.i_err = 1;
        step();
        bus.i_ack = 0; bus.i_err = 0;

        // Reset mid-transaction, then a late ack must be discarded.
        step();
        rst = 1;
        step();
        rst = 0; bus.i_a_cyc = 0; bus.i_a_stb = 0; bus.i_ack = 1;
        step(); step();
        bus.i_ack = 0;

        // Silent slave.
        do_reset();
        bus.i_a_cyc = 1; bus.i_a_stb = 1; new_attr_a();
        for (int i = 0; i <= 12; i++) begin
            #4;
`ifdef WBARB_TIMEOUT_EN
            e_err = (i == 5);
            e_stb = (i >= 1 && i <= 4);
`else
            e_err = 1'b0;
            e_stb = (i >= 1);
`endif
            chk("tmo_grant", 64'(bus.o_grant), (i >= 1) ? 64'd1 : 64'd0);
            chk("tmo_err", 64'(bus.o_a_err), 64'(e_err));
            chk("tmo_stb", 64'(bus.o_stb), 64'(e_stb));
            @(posedge clk);
            #1;
        end
        do_reset();

        // Randomized traffic; slave answers within two waits so no timeout fires.
        a_n = 0; b_n = 0; wait_c = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!bus.i_a_cyc && $urandom_range(0, 2) == 0) begin
                bus.i_a_cyc = 1; bus.i_a_stb = 1; a_n = $urandom_range(1, 3); new_attr_a();
            end
            if (!bus.i_b_cyc && $urandom_range(0, 2) == 0) begin
                bus.i_b_cyc = 1; bus.i_b_stb = 1; b_n = $urandom_range(1, 3); new_attr_b();
            end
            ostb = (own == 1 && bus.i_a_cyc && bus.i_a_stb) ||
                   (own == 2 && bus.i_b_cyc && bus.i_b_stb);
            bus.i_ack = 0; bus.i_err = 0;
            if (ostb) begin
                if (wait_c == 0) begin
                    if ($urandom_range(0, 7) == 0) bus.i_err = 1;
                    else bus.i_ack = 1;
                    if ($urandom_range(0, 5) == 0) bus.i_ack = 1;
                    wait_c = $urandom_range(0, 2);
                end else begin
                    wait_c--;
                end
            end else if ($urandom_range(0, 9) == 0) begin
                bus.i_ack = 1;
            end
            bus.i_data = $urandom;
            rst = ($urandom_range(0, 299) == 0);
            a_resp = ostb && own == 1 && (bus.i_ack || bus.i_err);
            b_resp = ostb && own == 2 && (bus.i_ack || bus.i_err);
            step();
            if (rst) begin
                rst = 0;
                bus.i_a_cyc = 0; bus.i_a_stb = 0;
                bus.i_b_cyc = 0; bus.i_b_stb = 0;
                wait_c = 0;
            end else begin
                if (a_resp) begin
                    a_n--;
                    if (a_n == 0 || bus.i_err) begin
                        bus.i_a_cyc = 0; bus.i_a_stb = 0;
                    end else begin
                        new_attr_a();
                    end
                end
                if (b_resp) begin
                    b_n--;
                    if (b_n == 0 || bus.i_err) begin
                        bus.i_b_cyc = 0; bus.i_b_stb = 0;
                    end else begin
                        new_attr_b();
                    end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
